uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//  Serial-to-parallel UART receiver; first stage behind the rx pin inside top_uart.
//  Converts an async 8N1 line (LSB first) into bytes with a one-cycle valid strobe.
//  Feeds the loopback/tx path. Flags frames whose stop bit is bad.
// PARAMETERS
//  CLK_FREQ  50_000_000  system clock frequency, Hz
//  BAUD      9600        line rate, bit/s
//  BPS_CNT   CLK_FREQ/BAUD (5208)  clocks per bit; derived, never overridden directly
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  rx          in   1  async serial line, idle high
//  rx_data     out  8  last good byte; holds until the next good frame
//  rx_valid    out  1  1-cycle strobe: rx_data updated this cycle
//  frame_err   out  1  1-cycle strobe: stop bit sampled low, byte dropped
//  parity_err  out  1  1-cycle strobe: parity mismatch (tied 0 without UART_RX_PARITY_EN)
// BEHAVIOUR
//  Reset: rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, state=IDLE,
//   counters=0, sync flops=1 (line idle). Reset mid-frame aborts it, no strobe.
//  Input: rx -> 2-flop synchroniser -> 1 delay flop; start = 1->0 edge on synced line.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE : wait for falling edge; clear baud_cnt, bit_cnt.
//   START: sample at baud_cnt==BPS_CNT/2-1. Line high -> glitch, back to IDLE,
//          no strobe. Line low -> DATA, baud_cnt restarts.
//   DATA : sample each bit at baud_cnt==BPS_CNT-1 (mid-bit); shift in LSB first
//          (bit_cnt 0..7); after bit 7 -> STOP (or PARITY).
//   STOP : sample at mid-bit. 1 -> rx_data<=shift, rx_valid=1 next cycle.
//          0 -> frame_err=1, rx_data unchanged. Either way -> IDLE immediately.
//  Rearm at stop mid-bit: back-to-back frames accepted, no idle gap required.
//  Line stuck low after frame_err: no retrigger until a new 1->0 edge.
//  Latency: strobe 1 cycle after the stop-bit sample,
//   ~9.5*BPS_CNT+3 clk from the start edge at the pin.
//  rx_valid, frame_err, parity_err mutually exclusive; never high 2 cycles in a row.
//  baud_cnt width = $clog2(BPS_CNT); bit_cnt 3 bits, no wrap beyond 7.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame 8E1; PARITY state samples bit 9 at mid-bit;
//   ^{data,parity}!=0 -> parity_err strobe at stop sample, rx_data unchanged,
//   rx_valid suppressed. Bad stop bit takes precedence: frame_err only.
//  Undefined: 8N1, no PARITY state, parity_err tied 0.
// STRUCTURE
//  uart_pkg: CLK_FREQ, BAUD, BPS_CNT defaults; state localparams
//   (IDLE, START, DATA, PARITY, STOP); shared with uart_byte_tx.
//  Sub-module uart_bit_timer: baud_cnt with clear input and half/full-bit tick
//   outputs; reused by the tx side.
// TESTING (50 MHz clk, 104160 ns/bit)
//  1. 8N1 frame 0x55 after reset -> rx_data=8'h55, one rx_valid pulse, frame_err=0.
//  2. 16 bytes back-to-back from data.txt -> 16 rx_valid pulses, bytes in order.
//  3. rx low 1000 ns then high -> no strobe, FSM back in IDLE, next 0xA3 received.
//  4. Frame 0x3C with stop bit 0 -> frame_err pulse, rx_data keeps previous value.
//  5. rst_n low during bit 4 of 0xFF -> outputs at reset values; next 0x12 received.
//  6. UART_RX_PARITY_EN: 0x07 with parity 0 -> parity_err pulse, no rx_valid;
//     parity 1 -> rx_data=8'h07, rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults and receiver/transmitter state encoding.
package uart_pkg;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD = 9600;
  localparam int BPS_CNT = CLK_FREQ / BAUD;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with clear and half/full-bit ticks.
module uart_bit_timer #(
  parameter int BPS_CNT = uart_pkg::BPS_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_half,
  output logic o_full
);
  localparam int W = $clog2(BPS_CNT);
  logic [W-1:0] r_cnt;
  assign o_half = r_cnt == W'(BPS_CNT / 2 - 1);
  assign o_full = r_cnt == W'(BPS_CNT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_clr || o_full) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with valid/frame-error strobes;
// defining UART_RX_PARITY_EN switches to 8E1 and enables the parity_err strobe.
module uart_byte_rx #(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD = uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err
);
  import uart_pkg::*;
  localparam int BPS_CNT = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif
  uart_state_e r_state, w_next;
  logic r_sync1, r_sync2, r_dly;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic w_fall, w_half, w_full, w_clr, w_stop_tick, w_par_bad, w_valid_nxt, w_ferr_nxt;
  assign w_fall = r_dly && !r_sync2;
  uart_bit_timer #(.BPS_CNT(BPS_CNT)) u_timer (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .o_half(w_half), .o_full(w_full)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next = START;
      START:   if (w_half) w_next = r_sync2 ? IDLE : DATA;
      DATA:    if (w_full && r_bit_cnt == 3'd7) w_next = AFTER_DATA;
      PARITY:  if (w_full) w_next = STOP;
      STOP:    if (w_full) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_clr = r_state == IDLE || (r_state == START && w_half);
    w_stop_tick = r_state == STOP && w_full;
    w_valid_nxt = w_stop_tick && r_sync2 && !w_par_bad;
    w_ferr_nxt = w_stop_tick && !r_sync2;
  end
  // Sync flops reset high so the idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {r_dly, r_sync2, r_sync1} <= 3'b111;
      r_bit_cnt <= '0;
      r_shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {r_dly, r_sync2, r_sync1} <= {r_sync2, r_sync1, rx};
      rx_valid <= w_valid_nxt;
      frame_err <= w_ferr_nxt;
      if (w_valid_nxt) rx_data <= r_shift;
      if (r_state == IDLE) r_bit_cnt <= '0;
      else if (r_state == DATA && w_full) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
  logic r_par;
  assign w_par_bad = ^{r_shift, r_par};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_par <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (r_state == PARITY && w_full) r_par <= r_sync2;
      parity_err <= w_stop_tick && r_sync2 && w_par_bad;
    end
`else
  assign w_par_bad = 1'b0;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: randomized self-checking bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD = 3_125_000;
  localparam int BPS = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, parity_err;
  int total = 0, bad = 0;
  int n_ferr = 0, n_perr = 0, n_viol = 0, cyc = 0, last_strobe_cyc = -1;
  logic prev_any = 1'b0;
  logic [7:0] q_got[$];
  logic [7:0] last_good = 8'h00;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      q_got.push_back(rx_data);
      last_strobe_cyc = cyc;
    end
    n_ferr += int'(frame_err);
    n_perr += int'(parity_err);
    if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1 ||
        (prev_any && (rx_valid || frame_err || parity_err))) n_viol++;
    prev_any = rx_valid || frame_err || parity_err;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit(^d ^ pflip);
    send_bit(stop);
  endtask

  task automatic check_byte(input string name, input logic [7:0] d);
    q_got.delete();
    send_frame(d, 1'b1, 1'b0);
    last_good = d;
    total++;
    if (q_got.size() !== 1) begin
      bad++;
      $display("FAIL %s strobes: got %0d want 1", name, q_got.size());
    end
    total++;
    if (rx_data !== d) begin
      bad++;
      $display("FAIL %s rx_data: got %h want %h", name, rx_data, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset parity_err: got %b want 0", parity_err); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int c0, f0, lat, exp_lat;
    f0 = n_ferr;
    c0 = cyc;
    check_byte("single_55", 8'h55);
    lat = last_strobe_cyc - c0;
    exp_lat = BPS * 19 / 2 + 3 + (PAR ? BPS : 0);
    total++;
    if (lat < exp_lat - 2 || lat > exp_lat + 2) begin
      bad++;
      $display("FAIL single latency: got %0d want %0d +-2", lat, exp_lat);
    end
    total++;
    if (n_ferr !== f0) begin bad++; $display("FAIL single frame_err: got %0d want %0d", n_ferr, f0); end
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    q_got.delete();
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0);
    end
    last_good = d;
    send_bit(1'b1);
    total++;
    if (q_got.size() !== 16) begin bad++; $display("FAIL b2b count: got %0d want 16", q_got.size()); end
    for (int i = 0; i < 16; i++)
      if (i < q_got.size()) begin
        total++;
        if (q_got[i] !== exp_q[i]) begin bad++; $display("FAIL b2b byte%0d: got %h want %h", i, q_got[i], exp_q[i]); end
      end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = n_ferr;
    q_got.delete();
    rx = 1'b0;
    repeat (BPS / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    total++;
    if (q_got.size() !== 0 || n_ferr !== f0) begin
      bad++;
      $display("FAIL glitch strobes: got valid=%0d ferr=%0d want 0 0", q_got.size(), n_ferr - f0);
    end
    check_byte("glitch_a3", 8'hA3);
    send_bit(1'b1);
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = n_ferr;
    q_got.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    total++; if (n_ferr !== f0 + 1) begin bad++; $display("FAIL ferr count: got %0d want %0d", n_ferr - f0, 1); end
    total++; if (q_got.size() !== 0) begin bad++; $display("FAIL ferr valid: got %0d want 0", q_got.size()); end
    total++; if (rx_data !== last_good) begin bad++; $display("FAIL ferr rx_data: got %h want %h", rx_data, last_good); end
    rx = 1'b0;
    repeat (3 * BPS) @(negedge clk);
    total++;
    if (n_ferr !== f0 + 1 || q_got.size() !== 0) begin
      bad++;
      $display("FAIL stuck_low retrigger: got ferr=%0d valid=%0d want 1 0", n_ferr - f0, q_got.size());
    end
    repeat (2) send_bit(1'b1);
    check_byte("after_ferr", 8'($urandom));
    send_bit(1'b1);
  endtask

  task automatic test_reset_mid();
    q_got.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (BPS / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rstmid strobes: got %b%b want 00", rx_valid, frame_err); end
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (6 * BPS) @(negedge clk);
    total++; if (q_got.size() !== 0) begin bad++; $display("FAIL rstmid aborted: got %0d strobes want 0", q_got.size()); end
    check_byte("rstmid_12", 8'h12);
    send_bit(1'b1);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic good;
    int f0, exp_ferr, gap;
    f0 = n_ferr;
    exp_ferr = 0;
    q_got.delete();
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      good = $urandom_range(0, 3) != 0;
      send_frame(d, good, 1'b0);
      if (good) begin
        exp_q.push_back(d);
        last_good = d;
      end else exp_ferr++;
      gap = good ? $urandom_range(0, 2) : $urandom_range(1, 2);
      repeat (gap) send_bit(1'b1);
    end
    send_bit(1'b1);
    total++;
    if (q_got.size() !== exp_q.size()) begin bad++; $display("FAIL rand count: got %0d want %0d", q_got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (i < q_got.size()) begin
        total++;
        if (q_got[i] !== exp_q[i]) begin bad++; $display("FAIL rand byte%0d: got %h want %h", i, q_got[i], exp_q[i]); end
      end
    total++;
    if (n_ferr - f0 !== exp_ferr) begin bad++; $display("FAIL rand ferr: got %0d want %0d", n_ferr - f0, exp_ferr); end
    total++;
    if (rx_data !== last_good) begin bad++; $display("FAIL rand rx_data: got %h want %h", rx_data, last_good); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    p0 = n_perr;
    q_got.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    total++; if (n_perr !== p0 + 1) begin bad++; $display("FAIL parity err count: got %0d want 1", n_perr - p0); end
    total++; if (q_got.size() !== 0) begin bad++; $display("FAIL parity valid: got %0d want 0", q_got.size()); end
    total++; if (rx_data !== last_good) begin bad++; $display("FAIL parity rx_data: got %h want %h", rx_data, last_good); end
    send_bit(1'b1);
    check_byte("parity_ok_07", 8'h07);
    send_bit(1'b1);
  endtask
`endif

  task automatic test_protocol();
    total++;
    if (n_viol !== 0) begin bad++; $display("FAIL strobe_exclusive: got %0d violations want 0", n_viol); end
    if (!PAR) begin
      total++;
      if (n_perr !== 0) begin bad++; $display("FAIL parity_tied: got %0d pulses want 0", n_perr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
